// File: rtl/sc_io_ports_pkg.sv
// Shared definitions for the memory-mapped I/O block: window base,
// register indices and the 7-segment glyph decoder.
package sc_io_ports_pkg;

  localparam logic [23:0] IO_BASE    = 24'hFFFFFF;

  localparam logic [3:0]  REG_SW     = 4'd0;
  localparam logic [3:0]  REG_KEYLVL = 4'd1;
  localparam logic [3:0]  REG_KEYEVT = 4'd2;
  localparam logic [3:0]  REG_LED    = 4'd3;
  localparam logic [3:0]  REG_HEX0   = 4'd4;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // Active-low segment pattern, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] seg7(input logic [3:0] val, input logic blank);
    logic [6:0] seg;
    case (val)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = seg;
    end
    return seg;
  endfunction

endpackage

// File: rtl/sc_io_ports_debounce.sv
// Per-key synchroniser and debouncer. Keys are active-low at the pin;
// the accepted level is reported as 1 = pressed. A one-cycle press pulse
// fires on the same edge that a released->pressed level is accepted.
module io_key_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press
);

  logic       sync1_r;
  logic       sync2_r;
  logic       level_r;
  logic [7:0] cnt_r;

  logic       sample_s;
  logic       differ_s;
  logic       accept_s;

  // Compare the synchronised sample with the accepted level and decide acceptance.
  always_comb begin
    sample_s = ~sync2_r;
    differ_s = (sample_s != level_r);
    accept_s = differ_s && (cnt_r == 8'(DEB_CYC - 1));
    press    = accept_s && sample_s;
  end

  assign level = level_r;

  // Two-flop synchroniser plus stability counter; reset treats the key as released.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
      if (accept_s) begin
        level_r <= sample_s;
        cnt_r   <= 8'd0;
      end else if (differ_s) begin
        cnt_r   <= cnt_r + 8'd1;
      end else begin
        cnt_r   <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/sc_io_ports.sv
// Memory-mapped I/O controller for the 0xFFFFFF00-0xFFFFFFFF window:
// switches, debounced keys with sticky press events, LEDs and 7-segment digits.
module sc_io_ports
  import sc_io_ports_pkg::*;
#(
  parameter int N_HEX   = 6,
  parameter int SW_W    = 10,
  parameter int N_KEY   = 3,
  parameter int LED_W   = 10,
  parameter int DEB_CYC = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic                 we,
  input  logic                 re,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 rvalid,
  output logic                 io_sel,
  input  logic [SW_W-1:0]      sw,
  input  logic [N_KEY-1:0]     key,
  output logic [7*N_HEX-1:0]   hex,
  output logic [LED_W-1:0]     led
);

  logic [3:0]                 idx_s;
  logic                       wr_s;
  logic                       rd_s;
  logic [31:0]                rd_mux_s;
  logic [31:0]                hex_rd_s;
  logic [N_KEY-1:0]           evt_clr_s;
  logic [N_KEY-1:0]           evt_next_s;
  logic [N_KEY-1:0]           key_level_s;
  logic [N_KEY-1:0]           key_press_s;

  logic [SW_W-1:0]            sw_meta_r;
  logic [SW_W-1:0]            sw_sync_r;
  logic [N_KEY-1:0]           key_evt_r;
  logic [LED_W-1:0]           led_r;
  logic [31:0]                rdata_r;
  logic                       rvalid_r;
  logic [N_HEX-1:0][3:0]      hex_val_r;
  logic [N_HEX-1:0]           hex_blank_r;
  logic [N_HEX-1:0][6:0]      hex_seg_r;

  // Low address nibble and unused write-data bits are intentionally ignored.
  logic                       unused_bits_s;
  assign unused_bits_s = ^{addr[3:0], wdata};

  assign io_sel = (addr[31:8] == IO_BASE);
  assign idx_s  = addr[7:4];
  assign wr_s   = we && io_sel;
  assign rd_s   = re && io_sel;
  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign led    = led_r;
  assign hex    = hex_seg_r;

  genvar gk;
  generate
    for (gk = 0; gk < N_KEY; gk++) begin : g_key
      io_key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clock   (clock),
        .reset   (reset),
        .key_raw (key[gk]),
        .level   (key_level_s[gk]),
        .press   (key_press_s[gk])
      );
    end
  endgenerate

  // Sticky events: write-1-to-clear, but a press on the same cycle keeps the bit set.
  always_comb begin
    if (wr_s && (idx_s == REG_KEYEVT)) begin
      evt_clr_s = wdata[N_KEY-1:0];
    end else begin
      evt_clr_s = {N_KEY{1'b0}};
    end
    evt_next_s = (key_evt_r & ~evt_clr_s) | key_press_s;
  end

  // Read-back value of whichever digit register is addressed.
  always_comb begin
    hex_rd_s = 32'd0;
    for (int i = 0; i < N_HEX; i++) begin
      if (idx_s == 4'(32'(REG_HEX0) + i)) begin
        hex_rd_s = {27'd0, hex_blank_r[i], hex_val_r[i]};
      end else begin
        hex_rd_s = hex_rd_s;
      end
    end
  end

  // Read mux over current (pre-write) register contents.
  always_comb begin
    rd_mux_s = 32'd0;
    case (idx_s)
      REG_SW:     rd_mux_s[SW_W-1:0]  = sw_sync_r;
      REG_KEYLVL: rd_mux_s[N_KEY-1:0] = key_level_s;
      REG_KEYEVT: rd_mux_s[N_KEY-1:0] = key_evt_r;
      REG_LED:    rd_mux_s[LED_W-1:0] = led_r;
      default:    rd_mux_s            = hex_rd_s;
    endcase
  end

  // Switch sync, LED register, key events and the registered read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta_r <= {SW_W{1'b0}};
      sw_sync_r <= {SW_W{1'b0}};
      key_evt_r <= {N_KEY{1'b0}};
      led_r     <= {LED_W{1'b0}};
      rdata_r   <= 32'd0;
      rvalid_r  <= 1'b0;
    end else begin
      sw_meta_r <= sw;
      sw_sync_r <= sw_meta_r;
      key_evt_r <= evt_next_s;
      rvalid_r  <= rd_s;
      if (rd_s) begin
        rdata_r <= rd_mux_s;
      end
      if (wr_s && (idx_s == REG_LED)) begin
        led_r <= wdata[LED_W-1:0];
      end
    end
  end

  genvar gh;
  generate
    for (gh = 0; gh < N_HEX; gh++) begin : g_hex
      localparam logic [3:0] MY_IDX = 4'(32'(REG_HEX0) + gh);
      // Digit register; the segment pattern is decoded from the write data so it lands with the write.
      always_ff @(posedge clock) begin
        if (reset) begin
          hex_val_r[gh]   <= 4'd0;
          hex_blank_r[gh] <= 1'b1;
          hex_seg_r[gh]   <= SEG_BLANK;
        end else if (wr_s && (idx_s == MY_IDX)) begin
          hex_val_r[gh]   <= wdata[3:0];
          hex_blank_r[gh] <= wdata[4];
          hex_seg_r[gh]   <= seg7(wdata[3:0], wdata[4]);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sc_io_ports.sv
// Directed self-checking bench for sc_io_ports (default parameters).
module tb_sc_io_ports;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        io_sel;
  logic [9:0]  sw;
  logic [2:0]  key;
  logic [41:0] hex;
  logic [9:0]  led;

  int checks;
  int failures;

  sc_io_ports dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .re     (re),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .io_sel (io_sel),
    .sw     (sw),
    .key    (key),
    .hex    (hex),
    .led    (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clock);
    addr = a; re = 1'b1;
    @(negedge clock);
    re = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    logic [31:0] d; logic v;
    checks++; if (hex !== {6{7'h7F}}) begin failures++; $display("FAIL reset_hex got=%h exp=%h", hex, {6{7'h7F}}); end
    checks++; if (led !== 10'd0) begin failures++; $display("FAIL reset_led got=%h exp=0", led); end
    checks++; if (rvalid !== 1'b0 || rdata !== 32'd0) begin failures++; $display("FAIL reset_rd got=%b/%h exp=0/0", rvalid, rdata); end
    do_read(32'hFFFFFF10, d, v);
    checks++; if (v !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL reset_keylvl got=%b/%h exp=1/0", v, d); end
    @(negedge clock);
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%b exp=0", rvalid); end
  endtask

  task automatic test_hex;
    logic [31:0] d; logic v;
    do_write(32'hFFFFFF40, 32'h8);
    checks++; if (hex[6:0] !== 7'b0000000) begin failures++; $display("FAIL hex0_8 got=%h exp=00", hex[6:0]); end
    do_write(32'hFFFFFF50, 32'h3);
    checks++; if (hex[13:7] !== 7'b0110000) begin failures++; $display("FAIL hex1_3 got=%h exp=30", hex[13:7]); end
    do_write(32'hFFFFFF60, 32'hA);
    checks++; if (hex[20:14] !== 7'h08) begin failures++; $display("FAIL hex2_A got=%h exp=08", hex[20:14]); end
    checks++; if (hex[27:21] !== 7'h7F) begin failures++; $display("FAIL hex3_blank got=%h exp=7f", hex[27:21]); end
    do_write(32'hFFFFFF90, 32'h13);
    checks++; if (hex[41:35] !== 7'h7F) begin failures++; $display("FAIL hex5_blankbit got=%h exp=7f", hex[41:35]); end
    do_read(32'hFFFFFF90, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h13) begin failures++; $display("FAIL hex5_read got=%b/%h exp=1/13", v, d); end
    do_read(32'hFFFFFF5C, d, v);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL hex1_read got=%h exp=3", d); end
    do_write(32'hFFFFFF40, 32'h0);
    checks++; if (hex[6:0] !== 7'h40) begin failures++; $display("FAIL hex0_0 got=%h exp=40", hex[6:0]); end
  endtask

  task automatic test_key;
    logic [31:0] d; logic v;
    @(negedge clock); key = 3'b101;
    wait_cycles(8);
    do_read(32'hFFFFFF10, d, v);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL keylvl_press got=%h exp=2", d); end
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL keyevt_press got=%h exp=2", d); end
    @(negedge clock); key = 3'b100;
    @(negedge clock); key = 3'b101;
    @(negedge clock); key = 3'b111;
    @(negedge clock); key = 3'b101;
    wait_cycles(8);
    do_read(32'hFFFFFF10, d, v);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL keylvl_glitch got=%h exp=2", d); end
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL keyevt_glitch got=%h exp=2", d); end
    @(negedge clock); key = 3'b111;
    wait_cycles(8);
    do_read(32'hFFFFFF10, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL keylvl_release got=%h exp=0", d); end
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL keyevt_sticky got=%h exp=2", d); end
  endtask

  task automatic test_w1c;
    logic [31:0] d; logic v;
    do_write(32'hFFFFFF20, 32'h0);
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL evt_w0 got=%h exp=2", d); end
    do_write(32'hFFFFFF20, 32'h2);
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL evt_w1c got=%h exp=0", d); end
    // Press key1; acceptance lands on the 6th rising edge, aligned with the clear.
    @(negedge clock); key = 3'b101;
    wait_cycles(5);
    addr = 32'hFFFFFF20; wdata = 32'h2; we = 1'b1;
    @(negedge clock); we = 1'b0;
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL evt_set_wins got=%h exp=2", d); end
    do_write(32'hFFFFFF20, 32'h2);
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL evt_clear_after got=%h exp=0", d); end
    @(negedge clock); key = 3'b111;
    wait_cycles(8);
  endtask

  task automatic test_sw;
    logic [31:0] d; logic v;
    @(negedge clock); sw = 10'b1111100000;
    wait_cycles(3);
    do_read(32'hFFFFFF00, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h3E0) begin failures++; $display("FAIL sw_read got=%b/%h exp=1/3e0", v, d); end
    do_read(32'h00000000, d, v);
    checks++; if (v !== 1'b0 || d !== 32'h3E0) begin failures++; $display("FAIL outside_read got=%b/%h exp=0/3e0", v, d); end
    do_read(32'hFFFFFFF0, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%b/%h exp=1/0", v, d); end
    @(negedge clock); addr = 32'hFFFFFF30; #1;
    checks++; if (io_sel !== 1'b1) begin failures++; $display("FAIL io_sel_in got=%b exp=1", io_sel); end
    addr = 32'h00001000; #1;
    checks++; if (io_sel !== 1'b0) begin failures++; $display("FAIL io_sel_out got=%b exp=0", io_sel); end
  endtask

  task automatic test_led;
    logic [31:0] d; logic v;
    do_write(32'h00000030, 32'h3FF);
    checks++; if (led !== 10'd0) begin failures++; $display("FAIL led_outside got=%h exp=0", led); end
    do_write(32'hFFFFFF30, 32'h155);
    checks++; if (led !== 10'h155) begin failures++; $display("FAIL led_write got=%h exp=155", led); end
    @(negedge clock);
    addr = 32'hFFFFFF30; wdata = 32'h0AA; we = 1'b1; re = 1'b1;
    @(negedge clock);
    we = 1'b0; re = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h155) begin failures++; $display("FAIL rw_same got=%b/%h exp=1/155", rvalid, rdata); end
    checks++; if (led !== 10'h0AA) begin failures++; $display("FAIL rw_led got=%h exp=0aa", led); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic v;
    do_write(32'hFFFFFF30, 32'h155);
    @(negedge clock); key = 3'b110;
    wait_cycles(3);
    addr = 32'hFFFFFF30; re = 1'b1; reset = 1'b1;
    @(negedge clock);
    re = 1'b0; reset = 1'b0;
    checks++; if (rvalid !== 1'b0 || rdata !== 32'd0) begin failures++; $display("FAIL midrst_rd got=%b/%h exp=0/0", rvalid, rdata); end
    checks++; if (led !== 10'd0) begin failures++; $display("FAIL midrst_led got=%h exp=0", led); end
    checks++; if (hex !== {6{7'h7F}}) begin failures++; $display("FAIL midrst_hex got=%h exp=%h", hex, {6{7'h7F}}); end
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_evt got=%h exp=0", d); end
    wait_cycles(8);
    do_read(32'hFFFFFF10, d, v);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL held_lvl got=%h exp=1", d); end
    do_read(32'hFFFFFF20, d, v);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL held_evt got=%h exp=1", d); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; addr = 32'd0; we = 1'b0; re = 1'b0; wdata = 32'd0;
    sw = 10'd0; key = 3'b111;
    wait_cycles(3);
    reset = 1'b0;
    test_reset;
    test_hex;
    test_key;
    test_w1c;
    test_sw;
    test_led;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
